// File: rtl/cond_status_unit.sv
// rtl/cond_status_unit.sv - condition-code evaluator with NZCV status register and pending flag-writer tracking
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   bundle handshake; accept = in_valid & in_ready
//   in_cond             NUM_PORTS 4-bit condition fields, port k at [4k+3:4k]
//   in_sets_flags       presented bundle contains one flag-setting instruction
//   flag_wr_en/_data    NZCV writeback from execute (bit3=N, bit2=Z, bit1=C, bit0=V)
//   flush               discards all outstanding flag writers
//   out_valid, out_met  registered per-port condition results, one cycle after accept
//   status_q            architectural NZCV register
//   pending_cnt         number of outstanding flag writers
module cond_status_unit #(
    parameter int NUM_PORTS   = 2,
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [4*NUM_PORTS-1:0] in_cond,
    input  logic                   in_sets_flags,
    output logic                   in_ready,
    input  logic                   flag_wr_en,
    input  logic [3:0]             flag_wr_data,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [NUM_PORTS-1:0]   out_met,
    output logic [3:0]             status_q,
    output logic [CNT_W-1:0]       pending_cnt
);

    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PENDING);

    logic                 wr_dec;
    logic [CNT_W-1:0]     eff_pending;
    logic                 accept;
    logic                 set_inc;
    logic [3:0]           eval_flags;
    logic [NUM_PORTS-1:0] met;

    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (code)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c && !z;
            4'h9:    r = !c || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // A writeback retires one outstanding writer; with nothing outstanding it
    // only updates the flags and must not wrap the counter.
    assign wr_dec      = flag_wr_en && (pending_cnt != '0);
    assign eff_pending = pending_cnt - CNT_W'(wr_dec);

    // Bundles that only read flags must wait for every writer to drain.
    // Flag-setting bundles may issue behind outstanding writers, bounded so
    // the counter can never pass MAX_PENDING.
    assign in_ready = !flush &&
                      (in_sets_flags ? (eff_pending < MAX_P) : (eff_pending == '0));

    assign accept  = in_valid && in_ready;
    assign set_inc = accept && in_sets_flags;

    // Same-cycle writeback is bypassed into evaluation.
    assign eval_flags = flag_wr_en ? flag_wr_data : status_q;

    always_comb begin
        met = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            met[k] = cond_eval(in_cond[4*k +: 4], eval_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= 4'b0000;
            pending_cnt <= '0;
            out_valid   <= 1'b0;
            out_met     <= '0;
        end else begin
            if (flag_wr_en) begin
                status_q <= flag_wr_data;
            end
            if (flush) begin
                pending_cnt <= '0;
            end else begin
                pending_cnt <= pending_cnt + CNT_W'(set_inc) - CNT_W'(wr_dec);
            end
            out_valid <= accept;
            if (accept) begin
                out_met <= met;
            end
        end
    end

endmodule

// File: tb/tb_cond_status_unit.sv
// tb/tb_cond_status_unit.sv - randomized self-checking bench for cond_status_unit
module tb_cond_status_unit;

    localparam int NP   = 2;
    localparam int MAXP = 3;
    localparam int CW   = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [4*NP-1:0] in_cond;
    logic          in_sets_flags;
    logic          in_ready;
    logic          flag_wr_en;
    logic [3:0]    flag_wr_data;
    logic          flush;
    logic          out_valid;
    logic [NP-1:0] out_met;
    logic [3:0]    status_q;
    logic [CW-1:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    int       m_status;
    int       m_pend;
    int       m_ov;
    int       m_met;
    int       last_ready;

    cond_status_unit #(
        .NUM_PORTS  (NP),
        .MAX_PENDING(MAXP),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_cond      (in_cond),
        .in_sets_flags(in_sets_flags),
        .in_ready     (in_ready),
        .flag_wr_en   (flag_wr_en),
        .flag_wr_data (flag_wr_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_met      (out_met),
        .status_q     (status_q),
        .pending_cnt  (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Condition truth from the mnemonic table, flags as NZCV integer.
    function automatic int model_cond(input int code, input int flags);
        int n, z, c, v;
        n = (flags >> 3) & 1;
        z = (flags >> 2) & 1;
        c = (flags >> 1) & 1;
        v = flags & 1;
        case (code)
            0:  return z;
            1:  return 1 - z;
            2:  return c;
            3:  return 1 - c;
            4:  return n;
            5:  return 1 - n;
            6:  return v;
            7:  return 1 - v;
            8:  return (c == 1 && z == 0) ? 1 : 0;
            9:  return (c == 0 || z == 1) ? 1 : 0;
            10: return (n == v) ? 1 : 0;
            11: return (n != v) ? 1 : 0;
            12: return (z == 0 && n == v) ? 1 : 0;
            13: return (z == 1 || n != v) ? 1 : 0;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    // One clock cycle: drive just after the edge, check ready mid-cycle,
    // advance the model, then check registered outputs after the next edge.
    task automatic step(input int r, input int v, input int c, input int s,
                        input int w, input int d, input int f);
        int eff, exp_ready, acc, flags, met;
        rst           = (r != 0);
        in_valid      = (v != 0);
        in_cond       = 8'(c);
        in_sets_flags = (s != 0);
        flag_wr_en    = (w != 0);
        flag_wr_data  = 4'(d);
        flush         = (f != 0);
        #1;
        eff = m_pend - ((w != 0 && m_pend != 0) ? 1 : 0);
        if (f != 0)      exp_ready = 0;
        else if (s != 0) exp_ready = (eff < MAXP) ? 1 : 0;
        else             exp_ready = (eff == 0) ? 1 : 0;
        last_ready = int'(in_ready);
        check("in_ready", last_ready, exp_ready);
        acc = (v != 0 && exp_ready != 0) ? 1 : 0;

        if (r != 0) begin
            m_status = 0;
            m_pend   = 0;
            m_ov     = 0;
            m_met    = 0;
        end else begin
            flags = (w != 0) ? (d & 15) : m_status;
            if (w != 0) m_status = d & 15;
            if (f != 0) m_pend = 0;
            else m_pend = m_pend + ((acc != 0 && s != 0) ? 1 : 0)
                                 - ((w != 0 && m_pend != 0) ? 1 : 0);
            m_ov = acc;
            if (acc != 0) begin
                met = 0;
                for (int k = 0; k < NP; k++)
                    met = met | (model_cond((c >> (4 * k)) & 15, flags) << k);
                m_met = met;
            end
        end

        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), m_ov);
        check("out_met", int'(out_met), m_met);
        check("status_q", int'(status_q), m_status);
        check("pending_cnt", int'(pending_cnt), m_pend);
        check("pending_bound", (int'(pending_cnt) <= MAXP) ? 1 : 0, 1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cond = '0; in_sets_flags = 1'b0;
        flag_wr_en = 1'b0; flag_wr_data = '0; flush = 1'b0;
        m_status = 0; m_pend = 0; m_ov = 0; m_met = 0; last_ready = 0;
        @(posedge clk);
        #1;

        // Reset state, with a writeback that reset must override
        step(1, 1, 8'hEE, 1, 1, 4'hF, 0);
        check("rst_status", int'(status_q), 0);
        check("rst_pend", int'(pending_cnt), 0);
        check("rst_ov", int'(out_valid), 0);
        check("rst_met", int'(out_met), 0);

        // {AL,NV}: port1 AL, port0 NV
        step(0, 1, 8'hEF, 0, 0, 0, 0);
        check("al_nv_valid", int'(out_valid), 1);
        check("al_nv_met", int'(out_met), 2'b10);
        check("al_nv_status", int'(status_q), 0);
        idle();
        check("valid_drops", int'(out_valid), 0);
        check("met_holds", int'(out_met), 2'b10);

        // Flag setter outstanding stalls a reader until writeback bypass
        step(0, 1, 8'hEE, 1, 0, 0, 0);
        step(0, 1, 8'h01, 0, 0, 0, 0);
        check("stall_ready", last_ready, 0);
        check("stall_pend", int'(pending_cnt), 1);
        step(0, 1, 8'h01, 0, 1, 4'b0100, 0);
        check("bypass_ready", last_ready, 1);
        check("bypass_met", int'(out_met), 2'b10);
        check("bypass_pend", int'(pending_cnt), 0);

        // Fill to MAX_PENDING, stall the next setter, flush
        step(0, 0, 0, 0, 1, 4'b0110, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'hEE, 1, 0, 0, 0);
        check("full_pend", int'(pending_cnt), 3);
        step(0, 1, 8'hEE, 1, 0, 0, 0);
        check("full_stall", last_ready, 0);
        check("full_pend2", int'(pending_cnt), 3);
        step(0, 0, 0, 0, 0, 0, 1);
        check("flush_pend", int'(pending_cnt), 0);
        check("flush_status", int'(status_q), 4'b0110);

        // Writeback with nothing pending, then {GE,LS} under NZCV=1001
        step(0, 0, 0, 0, 1, 4'b1001, 0);
        check("wr0_status", int'(status_q), 4'b1001);
        check("wr0_pend", int'(pending_cnt), 0);
        step(0, 1, 8'hA9, 0, 0, 0, 0);
        check("ge_ls_met", int'(out_met), 2'b11);

        // Setter accepted alongside retiring writeback keeps count at 1
        step(0, 1, 8'hEE, 1, 0, 0, 0);
        step(0, 1, 8'hEE, 1, 1, 4'b0011, 0);
        check("inc_dec_pend", int'(pending_cnt), 1);

        // Reset mid-operation with pending=2 and a writeback
        step(0, 1, 8'hEE, 1, 0, 0, 0);
        check("pre_rst_pend", int'(pending_cnt), 2);
        step(1, 0, 0, 0, 1, 4'hF, 0);
        check("mid_rst_status", int'(status_q), 0);
        check("mid_rst_pend", int'(pending_cnt), 0);
        check("mid_rst_ov", int'(out_valid), 0);
        step(0, 1, 8'h00, 0, 0, 0, 0);
        check("post_rst_ready", last_ready, 1);

        // Full sweep: every code on every flag value via the writeback bypass
        for (int fl = 0; fl < 16; fl++)
            for (int cd = 0; cd < 16; cd++)
                step(0, 1, ((15 - cd) << 4) | cd, 0, 1, fl, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step((($urandom % 64) == 0) ? 1 : 0,
                 (($urandom % 4) != 0) ? 1 : 0,
                 int'($urandom % 256),
                 (($urandom % 3) == 0) ? 1 : 0,
                 (($urandom % 4) == 0) ? 1 : 0,
                 int'($urandom % 16),
                 (($urandom % 16) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
